vend_change_controller: RTL and testbench
=========================================

# vend_change_controller

Sequential successor to the combinational coffee-type price/change calculator. It accumulates inserted coins into a credit register and validates a product selection against a parametrised price table. It then issues a vend request with a ready/valid handshake and pays the remaining credit back as change, one unit per clock. It sits between the coin acceptor / keypad front end and the dispenser and change-hopper drivers.

## Interface
Parameters:
- `NUM_PRODUCTS`, 4: number of selectable products (≥1).
- `CREDIT_W`, 4: width of the credit register and prices, in coin units.
- `COIN_W`, 3: width of the inserted coin value.
- `PRICES`, {4'd7,4'd5,4'd4,4'd3}: packed NUM_PRODUCTS×CREDIT_W. Product i's price is `PRICES[i*CREDIT_W +: CREDIT_W]`. The default prices are product 0 = 3, 1 = 4, 2 = 5, 3 = 7.
- `SEL_W` (derived): `$clog2(NUM_PRODUCTS)`, minimum 1.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `coin_valid` in 1: one-cycle strobe, coin inserted.
- `coin_value` in COIN_W: value of the inserted coin in units; 0 is legal and is a no-op add.
- `sel_valid` in 1: one-cycle strobe, product selected.
- `sel_id` in SEL_W: selected product index.
- `cancel` in 1: one-cycle strobe, return all credit.
- `vend_valid` out 1: dispense request, held until accepted.
- `vend_id` out SEL_W: product to dispense, stable while `vend_valid`.
- `vend_ready` in 1: dispenser accepts when `vend_valid && vend_ready`.
- `change_pulse` out 1: one pulse equals one unit of change.
- `credit` out CREDIT_W: current credit, registered.
- `reject` out 1: one-cycle pulse, a request was refused.
- `busy` out 1: high in VEND or REFUND.

## Operation
States: IDLE (credit = 0), CREDIT (credit > 0), VEND, REFUND.

Input priority in IDLE/CREDIT within one cycle is cancel > sel > coin. A lower-priority coin dropped in the same cycle produces `reject`.

Coin handling:
- Coin accepted in IDLE/CREDIT: `credit += coin_value`; go to CREDIT if the result is > 0.
- Overflow: if `credit + coin_value > 2^CREDIT_W−1`, the coin is rejected and credit is unchanged. Compute the sum at CREDIT_W+1 bits.
- Coin in VEND/REFUND: `reject`, credit unchanged.

Selection handling:
- Select in IDLE/CREDIT with `sel_id ≥ NUM_PRODUCTS`, or with credit < price: `reject`, state and credit unchanged.
- Valid select: `credit <= credit − price`, latch `vend_id`, go to VEND.
- Select in VEND/REFUND: ignored, no reject.

Cancel handling:
- Cancel in CREDIT: go to REFUND.
- Cancel in IDLE: no effect.
- Cancel in VEND/REFUND: ignored.

VEND and REFUND:
- VEND: `vend_valid` = 1. On handshake, go to IDLE if credit = 0, else to REFUND.
- REFUND: `change_pulse` = 1 each cycle and credit decrements by 1 in the same cycle. When the decrement brings credit to 0, go to IDLE.
- Change paid always equals the remaining credit exactly. Credit never underflows.

`busy` = (state == VEND || state == REFUND).

## Timing
- Reset (asynchronous, any state, including mid-VEND or mid-REFUND): state IDLE, `credit` = 0, `vend_valid` = 0, `vend_id` = 0, `change_pulse` = 0, `reject` = 0. Any pending credit is lost.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- Coin accepted at edge N: `credit` updated after edge N.
- Valid select at edge N: `vend_valid` = 1 and `credit` reduced from cycle N+1.
- `reject` is high for exactly the cycle following the offending edge.
- Handshake at edge M: `vend_valid` = 0 from cycle M+1.
- With remaining R > 0, `change_pulse` is high for cycles M+1…M+R, consecutively.
- IDLE is reached after edge M+R; `busy` is low from cycle M+R+1.
- Cancel at edge N with credit C: pulses occur in cycles N+1…N+C.
- `vend_ready` held high before VEND is harmless; the handshake completes on the first VEND cycle, giving 1-cycle latency.

## Test plan
- Insert 2, 2, select product 0 (price 3), `vend_ready` = 1 → `vend_valid` for 1 cycle with `vend_id` = 0, then exactly 1 `change_pulse`, then IDLE with credit 0.
- Insert 5, select product 3 (price 7) → `reject` pulse, credit stays 5. Insert 2, select 3 → vend, 0 change pulses, IDLE.
- Insert 7, 7, then a coin of 3 → third coin rejected (14 + 3 > 15), credit stays 14. Cancel → 14 consecutive `change_pulse`s, credit 0.
- Insert 6, select 1 with `vend_ready` = 0 for 5 cycles → `vend_valid` held and `vend_id` = 1 stable. During the stall, a coin → `reject`; a cancel → ignored. Raise `vend_ready` → 2 change pulses.
- Same-cycle cancel and coin of 3 with credit 4 → `reject`, then 4 change pulses. Same-cycle select 2 and coin of 1 with credit 5 → vend of product 2, coin rejected.
- Assert `rst_n` = 0 mid-REFUND with credit 3 remaining → `change_pulse` = 0 and credit = 0 immediately, IDLE after release.

Source files
------------

// File: rtl/vend_change_controller.sv
// Vending credit/change controller: accumulates coins, validates selections
// against a price table, handshakes a vend request, then pays change.
module vend_change_controller #(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W = 4,
  parameter int COIN_W = 3,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES =
    {4'd7, 4'd5, 4'd4, 4'd3},
  localparam int SEL_W =
    (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_value,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_id,
  input  logic                vend_ready,
  output logic                change_pulse,
  output logic [CREDIT_W-1:0] credit,
  output logic                reject,
  output logic                busy
);

  localparam int SUM_W =
    ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;
  localparam logic [SUM_W-1:0] CREDIT_MAX =
    SUM_W'({CREDIT_W{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_REFUND
  } state_t;

  state_t              state;
  state_t              nxt_state;
  logic [CREDIT_W-1:0] nxt_credit;
  logic [CREDIT_W-1:0] price;
  logic [SEL_W-1:0]    nxt_vend_id;
  logic                nxt_reject;
  logic [SUM_W-1:0]    sum;
  logic                accepting;
  logic                sel_ok;
  logic                coin_ovf;

  always_comb begin
    price = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel_id == SEL_W'(i)) begin
        price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  assign accepting = (state == S_IDLE) ||
                     (state == S_CREDIT);
  assign sel_ok = (32'(sel_id) < 32'(NUM_PRODUCTS)) &&
                  (credit >= price);
  assign sum = SUM_W'(credit) + SUM_W'(coin_value);
  assign coin_ovf = sum > CREDIT_MAX;

  // Priority while accepting: cancel, then select, then coin.
  always_comb begin
    nxt_state   = state;
    nxt_credit  = credit;
    nxt_vend_id = vend_id;
    nxt_reject  = 1'b0;
    unique case (1'b1)
      accepting && cancel: begin
        nxt_reject = coin_valid;
        if (state == S_CREDIT) begin
          nxt_state = S_REFUND;
        end
      end
      accepting && !cancel && sel_valid: begin
        nxt_reject = coin_valid || !sel_ok;
        if (sel_ok) begin
          nxt_credit  = credit - price;
          nxt_vend_id = sel_id;
          nxt_state   = S_VEND;
        end
      end
      accepting && !cancel && !sel_valid && coin_valid: begin
        if (coin_ovf) begin
          nxt_reject = 1'b1;
        end else begin
          nxt_credit = sum[CREDIT_W-1:0];
          if (sum != '0) begin
            nxt_state = S_CREDIT;
          end
        end
      end
      accepting && !cancel && !sel_valid && !coin_valid: begin
        nxt_state = state;
      end
      state == S_VEND: begin
        nxt_reject = coin_valid;
        if (vend_ready) begin
          nxt_state = (credit == '0) ? S_IDLE : S_REFUND;
        end
      end
      state == S_REFUND: begin
        nxt_reject = coin_valid;
        if (credit <= CREDIT_W'(1)) begin
          nxt_state  = S_IDLE;
          nxt_credit = '0;
        end else begin
          nxt_credit = credit - CREDIT_W'(1);
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      credit       <= '0;
      vend_id      <= '0;
      reject       <= 1'b0;
      vend_valid   <= 1'b0;
      change_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt_state;
      credit       <= nxt_credit;
      vend_id      <= nxt_vend_id;
      reject       <= nxt_reject;
      vend_valid   <= nxt_state == S_VEND;
      change_pulse <= nxt_state == S_REFUND;
      busy         <= (nxt_state == S_VEND) ||
                      (nxt_state == S_REFUND);
    end
  end

endmodule

// File: tb/tb_vend_change_controller.sv
// Directed bench for vend_change_controller with a transaction-level
// credit/refund model compared every cycle, plus literal spot checks.
module tb_vend_change_controller;

  localparam int NP = 4;
  localparam int CW = 4;
  localparam int KW = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          coin_valid = 1'b0;
  logic [KW-1:0] coin_value = '0;
  logic          sel_valid = 1'b0;
  logic [SW-1:0] sel_id = '0;
  logic          cancel = 1'b0;
  logic          vend_ready = 1'b0;
  logic          vend_valid;
  logic [SW-1:0] vend_id;
  logic          change_pulse;
  logic [CW-1:0] credit;
  logic          reject;
  logic          busy;

  int n_chk = 0;
  int n_fail = 0;
  int pulse_tot = 0;
  int p0 = 0;
  int price [NP] = '{3, 4, 5, 7};

  // Model: credit in units, a pending vend, and change units still owed.
  int m_credit = 0;
  int m_vid = 0;
  int m_left = 0;
  bit m_vend = 1'b0;
  bit m_rej = 1'b0;

  vend_change_controller dut (
    .clk(clk),
    .rst_n(rst_n),
    .coin_valid(coin_valid),
    .coin_value(coin_value),
    .sel_valid(sel_valid),
    .sel_id(sel_id),
    .cancel(cancel),
    .vend_valid(vend_valid),
    .vend_id(vend_id),
    .vend_ready(vend_ready),
    .change_pulse(change_pulse),
    .credit(credit),
    .reject(reject),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_credit = 0;
    m_vid = 0;
    m_left = 0;
    m_vend = 1'b0;
    m_rej = 1'b0;
  endfunction

  function automatic void model_step();
    int sid;
    sid = int'(sel_id);
    m_rej = 1'b0;
    if (m_vend) begin
      m_rej = coin_valid;
      if (vend_ready) begin
        m_vend = 1'b0;
        m_left = m_credit;
      end
    end else if (m_left > 0) begin
      m_rej = coin_valid;
      m_left--;
      m_credit--;
    end else if (cancel) begin
      m_rej = coin_valid;
      m_left = m_credit;
    end else if (sel_valid) begin
      m_rej = coin_valid;
      if (sid < NP && m_credit >= price[sid]) begin
        m_credit -= price[sid];
        m_vend = 1'b1;
        m_vid = sid;
      end else begin
        m_rej = 1'b1;
      end
    end else if (coin_valid) begin
      if (m_credit + int'(coin_value) > 2**CW - 1) m_rej = 1'b1;
      else m_credit += int'(coin_value);
    end
  endfunction

  task automatic compare_all();
    chk("credit", int'(credit), m_credit);
    chk("vend_valid", int'(vend_valid), int'(m_vend));
    chk("change_pulse", int'(change_pulse), int'(m_left > 0));
    chk("reject", int'(reject), int'(m_rej));
    chk("busy", int'(busy), int'(m_vend || m_left > 0));
    if (m_vend) chk("vend_id", int'(vend_id), m_vid);
    if (change_pulse) pulse_tot++;
  endtask

  task automatic cyc(bit cv, int cval, bit sv, int sid, bit cn);
    coin_valid = cv;
    coin_value = KW'(cval);
    sel_valid = sv;
    sel_id = SW'(sid);
    cancel = cn;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    coin_valid = 1'b0;
    coin_value = '0;
    sel_valid = 1'b0;
    sel_id = '0;
    cancel = 1'b0;
    compare_all();
  endtask

  task automatic coin(int v);
    cyc(1'b1, v, 1'b0, 0, 1'b0);
  endtask

  task automatic sel(int id);
    cyc(1'b0, 0, 1'b1, id, 1'b0);
  endtask

  task automatic can();
    cyc(1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic wait_idle(int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      idle(1);
      k++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);
    compare_all();
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(2);

    // 2 + 2, buy product 0 (3): one unit back
    vend_ready = 1'b1;
    coin(2);
    coin(2);
    chk("s1_credit4", int'(credit), 4);
    p0 = pulse_tot;
    sel(0);
    chk("s1_vend", int'(vend_valid), 1);
    chk("s1_vid", int'(vend_id), 0);
    chk("s1_credit", int'(credit), 1);
    wait_idle(40);
    chk("s1_pulses", pulse_tot - p0, 1);
    chk("s1_end_credit", int'(credit), 0);

    // Not enough credit, then exact price
    coin(5);
    sel(3);
    chk("s2_reject", int'(reject), 1);
    chk("s2_credit", int'(credit), 5);
    coin(2);
    p0 = pulse_tot;
    sel(3);
    chk("s2_vid", int'(vend_id), 3);
    wait_idle(40);
    chk("s2_pulses", pulse_tot - p0, 0);

    // Overflow reject, cancel refunds 14
    coin(7);
    coin(7);
    coin(3);
    chk("s3_ovf_rej", int'(reject), 1);
    chk("s3_credit", int'(credit), 14);
    p0 = pulse_tot;
    can();
    wait_idle(40);
    chk("s3_pulses", pulse_tot - p0, 14);

    // Exactly full credit is accepted
    coin(7);
    coin(7);
    coin(1);
    chk("s3b_full", int'(credit), 15);
    coin(1);
    chk("s3b_rej", int'(reject), 1);
    coin(0);
    chk("s3b_zero", int'(reject), 0);
    p0 = pulse_tot;
    can();
    wait_idle(40);
    chk("s3b_pulses", pulse_tot - p0, 15);

    // Stalled dispenser
    vend_ready = 1'b0;
    coin(6);
    sel(1);
    idle(1);
    coin(1);
    chk("s4_rej", int'(reject), 1);
    can();
    idle(2);
    chk("s4_held", int'(vend_valid), 1);
    chk("s4_vid", int'(vend_id), 1);
    chk("s4_credit", int'(credit), 2);
    vend_ready = 1'b1;
    p0 = pulse_tot;
    wait_idle(40);
    chk("s4_pulses", pulse_tot - p0, 2);

    // Same-cycle priority
    coin(4);
    p0 = pulse_tot;
    cyc(1'b1, 3, 1'b0, 0, 1'b1);
    chk("s5_cancel_rej", int'(reject), 1);
    wait_idle(40);
    chk("s5_pulses", pulse_tot - p0, 4);
    coin(5);
    cyc(1'b1, 1, 1'b1, 2, 1'b0);
    chk("s5_sel_rej", int'(reject), 1);
    chk("s5_vid", int'(vend_id), 2);
    chk("s5_credit", int'(credit), 0);
    wait_idle(40);

    // Select with no credit, cancel in idle
    sel(0);
    chk("s5b_rej", int'(reject), 1);
    can();
    chk("s5b_busy", int'(busy), 0);

    // Reset mid-refund
    coin(6);
    can();
    idle(3);
    chk("s6_credit3", int'(credit), 3);
    chk("s6_pulse", int'(change_pulse), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_rst_pulse", int'(change_pulse), 0);
    chk("s6_rst_credit", int'(credit), 0);
    chk("s6_rst_busy", int'(busy), 0);
    idle(1);
    rst_n = 1'b1;
    idle(2);
    chk("s6_after", int'(credit), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
